square_voice_bank: RTL

//  Polyphonic square-wave tone generator for the game's sound effects: VOICES

---
 rtl/square_voice_bank.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/square_voice_bank.sv
// Polyphonic square-wave tone generator: VOICES timed oscillators loaded through
// one write port, summed into a level and a first-order sigma-delta bitstream.
module square_voice_bank #(
    parameter int VOICES   = 4,
    parameter int PERIOD_W = 16,
    parameter int DUR_W    = 12,
    parameter int PRESCALE = 50000,
    localparam int VW      = (VOICES > 1) ? $clog2(VOICES) : 1,
    localparam int LVL_W   = $clog2(VOICES + 1)
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                ENABLE,
    input  logic                WR_EN,
    input  logic [VW-1:0]       WR_VOICE,
    input  logic [PERIOD_W-1:0] WR_HALF_PERIOD,
    input  logic [DUR_W-1:0]    WR_DURATION,
    output logic [VOICES-1:0]   VOICE_ACTIVE,
    output logic [VOICES-1:0]   NOTE_DONE,
    output logic [LVL_W-1:0]    AUDIO_LEVEL,
    output logic                AUDIO
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]   pre_q, pre_d;
    logic              dtick;
    logic [VOICES-1:0] active_w;
    logic [VOICES-1:0] done_w;
    logic [VOICES-1:0] high_w;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [LVL_W:0]    acc_q, acc_d;
    logic [LVL_W:0]    sum;
    logic              audio_q, audio_d;

    // Free-running duration prescaler; writes never restart it.
    assign dtick = ENABLE && (pre_q == PS_W'(PRESCALE - 1));

    always_comb begin
        pre_d = pre_q;
        if (ENABLE) begin
            pre_d = dtick ? '0 : pre_q + PS_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        logic [PERIOD_W-1:0] cur_hp_q;
        logic [PERIOD_W-1:0] pend_hp_q;
        logic [PERIOD_W-1:0] tick_q;
        logic [DUR_W-1:0]    remain_q;
        logic                sq_q;
        logic                active_q;
        logic                done_q;
        logic                wr_hit;
        logic                wrap;

        assign wr_hit = WR_EN && (32'(WR_VOICE) == v);
        assign wrap   = (cur_hp_q != '0) && (tick_q == cur_hp_q - PERIOD_W'(1));

        always_ff @(posedge CLK) begin
            if (!RST_N) begin
                cur_hp_q  <= '0;
                pend_hp_q <= '0;
                tick_q    <= '0;
                remain_q  <= '0;
                sq_q      <= 1'b0;
                active_q  <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (wr_hit) begin
                    if (WR_DURATION == '0) begin
                        active_q <= 1'b0;
                        sq_q     <= 1'b0;
                        tick_q   <= '0;
                    end else if (!active_q) begin
                        cur_hp_q  <= WR_HALF_PERIOD;
                        pend_hp_q <= WR_HALF_PERIOD;
                        tick_q    <= '0;
                        sq_q      <= 1'b0;
                        remain_q  <= WR_DURATION;
                        active_q  <= 1'b1;
                    end else begin
                        // Retune lands on the next toggle so no half is cut short;
                        // the reload also cancels any expiry in this cycle.
                        pend_hp_q <= WR_HALF_PERIOD;
                        remain_q  <= WR_DURATION;
                        if (cur_hp_q == '0) begin
                            cur_hp_q <= WR_HALF_PERIOD;
                        end else if (ENABLE) begin
                            if (wrap) begin
                                sq_q     <= ~sq_q;
                                tick_q   <= '0;
                                cur_hp_q <= WR_HALF_PERIOD;
                            end else begin
                                tick_q <= tick_q + PERIOD_W'(1);
                            end
                        end
                    end
                end else if (ENABLE && active_q) begin
                    if (cur_hp_q == '0) begin
                        sq_q   <= 1'b0;
                        tick_q <= '0;
                    end else if (wrap) begin
                        sq_q     <= ~sq_q;
                        tick_q   <= '0;
                        cur_hp_q <= pend_hp_q;
                    end else begin
                        tick_q <= tick_q + PERIOD_W'(1);
                    end
                    if (dtick) begin
                        remain_q <= remain_q - DUR_W'(1);
                        if (remain_q == DUR_W'(1)) begin
                            active_q <= 1'b0;
                            sq_q     <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end
                end
            end
        end

        assign active_w[v] = active_q;
        assign done_w[v]   = done_q;
        assign high_w[v]   = sq_q & active_q;
    end

    always_comb begin
        level_d = '0;
        for (int v = 0; v < VOICES; v++) begin
            level_d = level_d + LVL_W'(high_w[v]);
        end
    end

    // First-order sigma-delta: ones density equals AUDIO_LEVEL / VOICES.
    assign sum = acc_q + {1'b0, level_q};

    always_comb begin
        acc_d   = sum;
        audio_d = 1'b0;
        if (sum >= (LVL_W + 1)'(VOICES)) begin
            acc_d   = sum - (LVL_W + 1)'(VOICES);
            audio_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            level_q <= '0;
            acc_q   <= '0;
            audio_q <= 1'b0;
        end else if (ENABLE) begin
            level_q <= level_d;
            acc_q   <= acc_d;
            audio_q <= audio_d;
        end
    end

    assign VOICE_ACTIVE = active_w;
    assign NOTE_DONE    = done_w;
    assign AUDIO_LEVEL  = level_q;
    assign AUDIO        = audio_q;

endmodule
